// File: rtl/bitwise_alu_pkg.sv
// -----------------------------------------------------------------------------
// bitwise_alu_pkg
// Shared definitions for the bitwise logic ALU.
//   alu_op_e : 2-bit opcode enum (OR, NOR, AND, NAND)
//   ALU_OP_W : opcode width in bits
// -----------------------------------------------------------------------------
package bitwise_alu_pkg;

  localparam int ALU_OP_W = 2;

  // Bit 0 inverts the output, bit 1 chooses AND over OR.
  typedef enum logic [ALU_OP_W-1:0] {
    OP_OR   = 2'b00,
    OP_NOR  = 2'b01,
    OP_AND  = 2'b10,
    OP_NAND = 2'b11
  } alu_op_e;

endpackage : bitwise_alu_pkg

// File: rtl/bitwise_alu_comb.sv
// -----------------------------------------------------------------------------
// bitwise_alu_comb
// Purely combinational core of the bitwise ALU: applies the selected logic
// function to every bit of a and b and flags an all-zero result.
// Ports:
//   sel  [ALU_OP_W-1:0] in  : opcode (alu_op_e encoding)
//   a    [WIDTH-1:0]    in  : operand A
//   b    [WIDTH-1:0]    in  : operand B
//   y    [WIDTH-1:0]    out : result
//   zero                out : high when y is all zeros
// -----------------------------------------------------------------------------
module bitwise_alu_comb
  import bitwise_alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [ALU_OP_W-1:0] sel,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    y,
  output logic                zero
);

  alu_op_e op;
  logic    use_and;
  logic    invert;

  assign op = alu_op_e'(sel);

  // Every encoding is decoded explicitly, so no code can leave these unknown.
  assign use_and = (op == OP_AND) || (op == OP_NAND);
  assign invert  = (op == OP_NOR) || (op == OP_NAND);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic base;
    assign base  = use_and ? (a[gi] & b[gi]) : (a[gi] | b[gi]);
    assign y[gi] = base ^ invert;
  end

  assign zero = ~|y;

endmodule : bitwise_alu_comb

// File: rtl/bitwise_alu.sv
// -----------------------------------------------------------------------------
// bitwise_alu
// Bitwise logic ALU (OR / NOR / AND / NAND). Provides the combinational result
// for same-cycle use plus a one-cycle registered copy for pipelined consumers.
// Ports:
//   clk                  in  : clock, rising edge
//   rst                  in  : synchronous active-high reset (clears y_q only)
//   sel  [ALU_OP_W-1:0]  in  : opcode
//   a    [WIDTH-1:0]     in  : operand A
//   b    [WIDTH-1:0]     in  : operand B
//   y    [WIDTH-1:0]     out : combinational result
//   y_q  [WIDTH-1:0]     out : registered result (1-cycle latency)
//   zero                 out : combinational flag, y == 0
// -----------------------------------------------------------------------------
module bitwise_alu
  import bitwise_alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_OP_W-1:0] sel,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    y,
  output logic [WIDTH-1:0]    y_q,
  output logic                zero
);

  logic [WIDTH-1:0] y_d;

  bitwise_alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .sel  (sel),
    .a    (a),
    .b    (b),
    .y    (y_d),
    .zero (zero)
  );

  assign y = y_d;

  // No enable: the register follows y every cycle unless reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

endmodule : bitwise_alu

// File: tb/tb_bitwise_alu.sv
// -----------------------------------------------------------------------------
// tb_bitwise_alu
// Self-checking bench for bitwise_alu at WIDTH=1 and WIDTH=8. Expected values
// come from a per-bit counting model of the opcode rules and from constants.
// Inputs change on the falling edge; outputs are sampled 1 ns later or 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bitwise_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       a1, b1;
  logic       y1, yq1, zero1;
  logic [7:0] a8, b8;
  logic [7:0] y8, yq8;
  logic       zero8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitwise_alu #(.WIDTH(1)) dut1 (
    .clk (clk), .rst (rst), .sel (sel), .a (a1), .b (b1),
    .y (y1), .y_q (yq1), .zero (zero1)
  );

  bitwise_alu #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .sel (sel), .a (a8), .b (b8),
    .y (y8), .y_q (yq8), .zero (zero8)
  );

  // Reference: count the ones in each bit pair; OR means "at least one",
  // AND means "both", and the low opcode bit complements the answer.
  function automatic logic [7:0] ref_op(input logic [1:0] s,
                                        input logic [7:0] x,
                                        input logic [7:0] z);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int ones;
      logic bit_v;
      ones  = int'(x[i]) + int'(z[i]);
      bit_v = (s[1] == 1'b1) ? (ones == 2) : (ones >= 1);
      r[i]  = (s[0] == 1'b1) ? !bit_v : bit_v;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0] w8_exp [4];
  logic [7:0] prev1, prev8, exp1, exp8;
  logic       prev_rst;

  initial begin
    w8_exp[0] = 8'hFC; w8_exp[1] = 8'h03; w8_exp[2] = 8'h30; w8_exp[3] = 8'hCF;

    // Reset state
    rst = 1'b1; sel = 2'b00; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_yq1", {7'b0, yq1}, 8'h00);
    chk("reset_yq8", yq8, 8'h00);

    // Exhaustive WIDTH=1 sweep of {a, b, sel}, one step per 10 ns
    rst = 1'b0;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vec;
      @(negedge clk);
      vec = 4'(v);
      {a1, b1, sel} = vec;
      #1;
      exp1 = ref_op(sel, {7'b0, a1}, {7'b0, b1}) & 8'h01;
      chk($sformatf("sweep_y a=%0b b=%0b sel=%0b", a1, b1, sel), {7'b0, y1}, exp1);
      chk($sformatf("sweep_zero v=%0d", v), {7'b0, zero1}, {7'b0, (exp1 == 8'h00)});
    end

    // Truth-table spot constants
    @(negedge clk); a1 = 1'b0; b1 = 1'b0; sel = 2'b01; #1;
    chk("tt_00_nor", {7'b0, y1}, 8'h01);
    @(negedge clk); a1 = 1'b1; b1 = 1'b1; sel = 2'b10; #1;
    chk("tt_11_and", {7'b0, y1}, 8'h01);
    @(negedge clk); a1 = 1'b0; b1 = 1'b1; sel = 2'b11; #1;
    chk("tt_01_nand", {7'b0, y1}, 8'h01);

    // Registered path
    @(negedge clk); a1 = 1'b1; b1 = 1'b0; sel = 2'b11; #1;
    chk("reg_y_immediate", {7'b0, y1}, 8'h01);
    @(posedge clk); #1;
    chk("reg_yq_after_edge", {7'b0, yq1}, 8'h01);

    // Reset held for two cycles, then released
    @(negedge clk); rst = 1'b1; a1 = 1'b1; b1 = 1'b1; sel = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_yq", {7'b0, yq1}, 8'h00);
    chk("rst_hold_y", {7'b0, y1}, 8'h01);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_yq", {7'b0, yq1}, 8'h01);

    // Zero flag
    @(negedge clk); a1 = 1'b0; b1 = 1'b0; sel = 2'b00; #1;
    chk("zero_y", {7'b0, y1}, 8'h00);
    chk("zero_flag_set", {7'b0, zero1}, 8'h01);
    sel = 2'b01; #1;
    chk("zero_flag_clear", {7'b0, zero1}, 8'h00);

    // WIDTH=8 constants
    a8 = 8'hF0; b8 = 8'h3C;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); sel = 2'(s); #1;
      chk($sformatf("w8_sel%0d", s), y8, w8_exp[s]);
    end

    // Back-to-back opcode changes with fixed operands
    a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h0F;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); sel = 2'(s); #1;
      prev1 = ref_op(sel, {7'b0, a1}, {7'b0, b1}) & 8'h01;
      prev8 = ref_op(sel, a8, b8);
      @(posedge clk); #1;
      chk($sformatf("b2b_yq1 sel=%0d", s), {7'b0, yq1}, prev1);
      chk($sformatf("b2b_yq8 sel=%0d", s), yq8, prev8);
    end

    // Randomized traffic including occasional reset
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      sel = 2'($urandom_range(0, 3));
      a1  = 1'($urandom); b1 = 1'($urandom);
      a8  = 8'($urandom); b8 = 8'($urandom);
      rst = ($urandom_range(0, 9) == 0);
      #1;
      exp1 = ref_op(sel, {7'b0, a1}, {7'b0, b1}) & 8'h01;
      exp8 = ref_op(sel, a8, b8);
      chk($sformatf("rnd_y1 n=%0d", n), {7'b0, y1}, exp1);
      chk($sformatf("rnd_y8 n=%0d", n), y8, exp8);
      chk($sformatf("rnd_zero8 n=%0d", n), {7'b0, zero8}, {7'b0, (exp8 == 8'h00)});
      prev_rst = rst;
      @(posedge clk); #1;
      chk($sformatf("rnd_yq1 n=%0d", n), {7'b0, yq1}, prev_rst ? 8'h00 : exp1);
      chk($sformatf("rnd_yq8 n=%0d", n), yq8, prev_rst ? 8'h00 : exp8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bitwise_alu
